// File: rtl/ecc_pmul_seq.sv
// ecc_pmul_seq: operand banks (k, Gx, Gy, Rx, Ry) and launch/capture sequencer for the ECC point-multiply core.
// Build option: define ECC_PMUL_KEY_WIPE_EN to scrub the scalar bank after every run.
module ecc_pmul_seq #(
  parameter int pOPERAND_WIDTH = 256,
  parameter int pWORD_WIDTH    = 32,
  parameter int pNUM_WORDS     = 8,
  parameter int pADDR_W        = 3,
  parameter int pTIMEOUT_W     = 32,
  parameter int pTIMEOUT       = 2**24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   host_wr,
  input  logic [1:0]             host_sel,
  input  logic [pADDR_W-1:0]     host_addr,
  input  logic [pWORD_WIDTH-1:0] host_wdata,
  input  logic                   host_rsel,
  output logic [pWORD_WIDTH-1:0] host_rdata,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout,
  output logic                   trigger_o,
  output logic                   core_ena,
  input  logic                   core_rdy,
  input  logic [pADDR_W-1:0]     core_k_addr,
  input  logic [pADDR_W-1:0]     core_gx_addr,
  input  logic [pADDR_W-1:0]     core_gy_addr,
  output logic [pWORD_WIDTH-1:0] core_k_word,
  output logic [pWORD_WIDTH-1:0] core_gx_word,
  output logic [pWORD_WIDTH-1:0] core_gy_word,
  input  logic [pADDR_W-1:0]     core_rx_addr,
  input  logic [pADDR_W-1:0]     core_ry_addr,
  input  logic                   core_rx_wren,
  input  logic                   core_ry_wren,
  input  logic [pWORD_WIDTH-1:0] core_rx_word,
  input  logic [pWORD_WIDTH-1:0] core_ry_word
);

  if (pOPERAND_WIDTH != pWORD_WIDTH * pNUM_WORDS) begin : g_width_check
    $error("ecc_pmul_seq: pOPERAND_WIDTH must equal pWORD_WIDTH*pNUM_WORDS");
  end

  // state | meaning
  // IDLE  | no run since reset; host may load operands
  // ARM   | one-cycle core launch pulse
  // RUN   | core computing; rdy handshake and timeout timer active
  // WIPE  | scalar bank scrubbed one word per cycle (key-wipe builds only)
  // DONE  | run finished (normally or by timeout); operands writable
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ARM  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
`ifdef ECC_PMUL_KEY_WIPE_EN
  localparam logic [2:0] S_WIPE = 3'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [pADDR_W:0]      NUM_WORDS_L = (pADDR_W+1)'(pNUM_WORDS);
  localparam logic [pTIMEOUT_W-1:0] TIMER_LAST  = pTIMEOUT_W'(pTIMEOUT - 1);

  typedef logic [pWORD_WIDTH-1:0] word_t;

  function automatic logic addr_ok(input logic [pADDR_W-1:0] a);
    return {1'b0, a} < NUM_WORDS_L;
  endfunction

  logic [2:0]            state_q, state_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic                  rdy_low_q, rdy_low_d;
  logic [pTIMEOUT_W-1:0] timer_q, timer_d;
  word_t                 k_q  [pNUM_WORDS];
  word_t                 k_d  [pNUM_WORDS];
  word_t                 gx_q [pNUM_WORDS];
  word_t                 gx_d [pNUM_WORDS];
  word_t                 gy_q [pNUM_WORDS];
  word_t                 gy_d [pNUM_WORDS];
  word_t                 rx_q [pNUM_WORDS];
  word_t                 rx_d [pNUM_WORDS];
  word_t                 ry_q [pNUM_WORDS];
  word_t                 ry_d [pNUM_WORDS];
  word_t                 host_rdata_q, host_rdata_d;
  word_t                 core_k_word_q, core_k_word_d;
  word_t                 core_gx_word_q, core_gx_word_d;
  word_t                 core_gy_word_q, core_gy_word_d;
  logic                  host_open;
  logic                  run_exit;
`ifdef ECC_PMUL_KEY_WIPE_EN
  localparam logic [pADDR_W-1:0] WIPE_LAST = pADDR_W'(pNUM_WORDS - 1);
  logic [pADDR_W-1:0] wipe_idx_q, wipe_idx_d;
`endif

  assign host_open = (state_q == S_IDLE) || (state_q == S_DONE);

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    rdy_low_d = rdy_low_q;
    timer_d   = timer_q;
    k_d       = k_q;
    gx_d      = gx_q;
    gy_d      = gy_q;
    rx_d      = rx_q;
    ry_d      = ry_q;
    run_exit  = 1'b0;
`ifdef ECC_PMUL_KEY_WIPE_EN
    wipe_idx_d = wipe_idx_q;
`endif

    // Host writes land on the same edge that accepts start, so the run sees them.
    if (host_wr && host_open && addr_ok(host_addr)) begin
      case (host_sel)
        2'd0:    k_d[host_addr]  = host_wdata;
        2'd1:    gx_d[host_addr] = host_wdata;
        2'd2:    gy_d[host_addr] = host_wdata;
        default: ;
      endcase
    end
    if (core_rx_wren && addr_ok(core_rx_addr)) rx_d[core_rx_addr] = core_rx_word;
    if (core_ry_wren && addr_ok(core_ry_addr)) ry_d[core_ry_addr] = core_ry_word;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ARM;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      S_ARM: begin
        state_d   = S_RUN;
        timer_d   = '0;
        rdy_low_d = 1'b0;
      end
      S_RUN: begin
        if (timer_q != '1) timer_d = timer_q + 1'b1;
        if (!core_rdy) rdy_low_d = 1'b1;
        if (rdy_low_q && core_rdy) begin
          run_exit = 1'b1;
        end else if (timer_q == TIMER_LAST) begin
          run_exit  = 1'b1;
          timeout_d = 1'b1;
        end
        if (run_exit) begin
`ifdef ECC_PMUL_KEY_WIPE_EN
          state_d    = S_WIPE;
          wipe_idx_d = '0;
`else
          state_d = S_DONE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef ECC_PMUL_KEY_WIPE_EN
      S_WIPE: begin
        k_d[wipe_idx_q] = '0;
        if (wipe_idx_q == WIPE_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wipe_idx_d = wipe_idx_q + 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Read ports see the pre-write bank contents, like a BRAM in read-first mode.
  always_comb begin
    host_rdata_d   = '0;
    core_k_word_d  = '0;
    core_gx_word_d = '0;
    core_gy_word_d = '0;
    if (addr_ok(host_addr))    host_rdata_d   = host_rsel ? ry_q[host_addr] : rx_q[host_addr];
    if (addr_ok(core_k_addr))  core_k_word_d  = k_q[core_k_addr];
    if (addr_ok(core_gx_addr)) core_gx_word_d = gx_q[core_gx_addr];
    if (addr_ok(core_gy_addr)) core_gy_word_d = gy_q[core_gy_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      rdy_low_q      <= 1'b0;
      timer_q        <= '0;
      k_q            <= '{default: '0};
      gx_q           <= '{default: '0};
      gy_q           <= '{default: '0};
      rx_q           <= '{default: '0};
      ry_q           <= '{default: '0};
      host_rdata_q   <= '0;
      core_k_word_q  <= '0;
      core_gx_word_q <= '0;
      core_gy_word_q <= '0;
    end else begin
      state_q        <= state_d;
      done_q         <= done_d;
      timeout_q      <= timeout_d;
      rdy_low_q      <= rdy_low_d;
      timer_q        <= timer_d;
      k_q            <= k_d;
      gx_q           <= gx_d;
      gy_q           <= gy_d;
      rx_q           <= rx_d;
      ry_q           <= ry_d;
      host_rdata_q   <= host_rdata_d;
      core_k_word_q  <= core_k_word_d;
      core_gx_word_q <= core_gx_word_d;
      core_gy_word_q <= core_gy_word_d;
    end
  end

`ifdef ECC_PMUL_KEY_WIPE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wipe_idx_q <= '0;
    else        wipe_idx_q <= wipe_idx_d;
  end
`endif

  assign busy         = !host_open;
  assign done         = done_q;
  assign timeout      = timeout_q;
  assign trigger_o    = (state_q == S_RUN);
  assign core_ena     = (state_q == S_ARM);
  assign host_rdata   = host_rdata_q;
  assign core_k_word  = core_k_word_q;
  assign core_gx_word = core_gx_word_q;
  assign core_gy_word = core_gy_word_q;

endmodule

// File: tb/tb_ecc_pmul_seq.sv
// Self-checking bench for ecc_pmul_seq in its 384-bit / 12-word configuration with a short run timeout.
module tb_ecc_pmul_seq;
  localparam int NW = 12;
  localparam int AW = 4;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          host_wr = 1'b0;
  logic [1:0]    host_sel = '0;
  logic [AW-1:0] host_addr = '0;
  logic [31:0]   host_wdata = '0;
  logic          host_rsel = 1'b0;
  logic [31:0]   host_rdata;
  logic          start = 1'b0;
  logic          busy, done, timeout, trigger_o, core_ena;
  logic          core_rdy = 1'b1;
  logic [AW-1:0] core_k_addr = '0, core_gx_addr = '0, core_gy_addr = '0;
  logic [31:0]   core_k_word, core_gx_word, core_gy_word;
  logic [AW-1:0] core_rx_addr = '0, core_ry_addr = '0;
  logic          core_rx_wren = 1'b0, core_ry_wren = 1'b0;
  logic [31:0]   core_rx_word = '0, core_ry_word = '0;

  always #5 clk = ~clk;

  ecc_pmul_seq #(
    .pOPERAND_WIDTH(384), .pWORD_WIDTH(32), .pNUM_WORDS(NW),
    .pADDR_W(AW), .pTIMEOUT_W(32), .pTIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_wr(host_wr), .host_sel(host_sel), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rsel(host_rsel), .host_rdata(host_rdata),
    .start(start), .busy(busy), .done(done), .timeout(timeout),
    .trigger_o(trigger_o), .core_ena(core_ena), .core_rdy(core_rdy),
    .core_k_addr(core_k_addr), .core_gx_addr(core_gx_addr), .core_gy_addr(core_gy_addr),
    .core_k_word(core_k_word), .core_gx_word(core_gx_word), .core_gy_word(core_gy_word),
    .core_rx_addr(core_rx_addr), .core_ry_addr(core_ry_addr),
    .core_rx_wren(core_rx_wren), .core_ry_wren(core_ry_wren),
    .core_rx_word(core_rx_word), .core_ry_word(core_ry_word)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int trig_cnt = 0, busy_cnt = 0, ena_cnt = 0;

  always @(posedge clk) begin
    if (trigger_o) trig_cnt <= trig_cnt + 1;
    if (busy)      busy_cnt <= busy_cnt + 1;
    if (core_ena)  ena_cnt  <= ena_cnt + 1;
  end

  // Reference model: plain word arrays; entries NW..15 model the unbacked address range.
  logic [31:0] k_m [16];
  logic [31:0] gx_m[16];
  logic [31:0] gy_m[16];
  logic [31:0] rx_m[16];
  logic [31:0] ry_m[16];

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_vec_t;
  wr_vec_t tbl[$];

  logic [31:0] p256_gx[8] = '{32'hD898C296, 32'hF4A13945, 32'h2DEB33A0, 32'h77037D81,
                              32'h63A440F2, 32'hF8BCE6E5, 32'hE12C4247, 32'h6B17D1F2};
  logic [31:0] p256_gy[8] = '{32'h37BF51F5, 32'hCBB64068, 32'h6B315ECE, 32'h2BCE3357,
                              32'h7C0F9E16, 32'h8EE7EB4A, 32'hFE1A7F9B, 32'h4FE342E2};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) begin
      k_m[i] = '0; gx_m[i] = '0; gy_m[i] = '0; rx_m[i] = '0; ry_m[i] = '0;
    end
  endfunction

  function automatic void model_write(input logic [1:0] sel, input logic [3:0] addr, input logic [31:0] data);
    if (int'(addr) < NW) begin
      case (sel)
        2'd0: k_m[addr]  = data;
        2'd1: gx_m[addr] = data;
        2'd2: gy_m[addr] = data;
        default: ;
      endcase
    end
  endfunction

  task automatic host_write(input logic [1:0] sel, input logic [3:0] addr, input logic [31:0] data);
    host_wr = 1'b1; host_sel = sel; host_addr = addr; host_wdata = data;
    tick();
    host_wr = 1'b0;
    model_write(sel, addr, data);
  endtask

  task automatic check_banks(input string tag);
    for (int i = 0; i < 16; i++) begin
      core_k_addr = AW'(i); core_gx_addr = AW'(i); core_gy_addr = AW'(i);
      host_addr = AW'(i); host_rsel = 1'b0;
      tick();
      chk($sformatf("%s_k[%0d]", tag, i),  core_k_word,  k_m[i]);
      chk($sformatf("%s_gx[%0d]", tag, i), core_gx_word, gx_m[i]);
      chk($sformatf("%s_gy[%0d]", tag, i), core_gy_word, gy_m[i]);
      chk($sformatf("%s_rx[%0d]", tag, i), host_rdata,   rx_m[i]);
      host_rsel = 1'b1;
      tick();
      chk($sformatf("%s_ry[%0d]", tag, i), host_rdata,   ry_m[i]);
    end
    host_rsel = 1'b0;
  endtask

  // One full run: the core model copies Gx->Rx and Gy->Ry through the core ports,
  // holding rdy low for NW+1 cycles, so RUN lasts NW+2 cycles.
  task automatic do_run(input string tag, input bit intrude, input bit wr_gx0, input logic [31:0] gx0_val);
    int t0, b0, e0, n;
    t0 = trig_cnt; b0 = busy_cnt; e0 = ena_cnt;
    start = 1'b1;
    if (wr_gx0) begin
      host_wr = 1'b1; host_sel = 2'd1; host_addr = '0; host_wdata = gx0_val;
      model_write(2'd1, 4'd0, gx0_val);
    end
    tick();
    start = 1'b0; host_wr = 1'b0;
    chk({tag, "_arm_ena"},  32'(core_ena), 32'd1);
    chk({tag, "_arm_busy"}, 32'(busy),     32'd1);
    chk({tag, "_arm_done"}, 32'(done),     32'd0);
    tick();
    chk({tag, "_run_trig"}, 32'(trigger_o), 32'd1);
    chk({tag, "_run_ena"},  32'(core_ena),  32'd0);
    core_rdy = 1'b0;
    for (int s = 0; s <= NW; s++) begin
      core_k_addr  = (s < NW) ? AW'(s) : '0;
      core_gx_addr = (s < NW) ? AW'(s) : '0;
      core_gy_addr = (s < NW) ? AW'(s) : '0;
      if (s > 0) begin
        core_rx_wren = 1'b1; core_ry_wren = 1'b1;
        core_rx_addr = AW'(s - 1); core_ry_addr = AW'(s - 1);
        core_rx_word = core_gx_word; core_ry_word = core_gy_word;
      end
      if (intrude && s == 3) begin
        host_wr = 1'b1; host_sel = 2'd0; host_addr = '0; host_wdata = 32'hDEADBEEF; start = 1'b1;
      end else begin
        host_wr = 1'b0; start = 1'b0;
      end
      tick();
    end
    core_rx_wren = 1'b0; core_ry_wren = 1'b0; host_wr = 1'b0; start = 1'b0;
    core_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rx_m[i] = gx_m[i];
      ry_m[i] = gy_m[i];
    end
`ifdef ECC_PMUL_KEY_WIPE_EN
    for (int i = 0; i < 16; i++) k_m[i] = '0;
`endif
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done"},       32'(done),      32'd1);
    chk({tag, "_timeout"},    32'(timeout),   32'd0);
    chk({tag, "_busy_end"},   32'(busy),      32'd0);
    chk({tag, "_trig_end"},   32'(trigger_o), 32'd0);
    chk({tag, "_trig_width"}, 32'(trig_cnt - t0), 32'(NW + 2));
    chk({tag, "_ena_pulses"}, 32'(ena_cnt - e0),  32'd1);
`ifdef ECC_PMUL_KEY_WIPE_EN
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(1 + NW + 2 + NW));
`else
    chk({tag, "_busy_cycles"}, 32'(busy_cnt - b0), 32'(1 + NW + 2));
`endif
  endtask

  initial begin
    int n, t0;
    model_clear();
    #12;
    chk("rst_busy",    32'(busy),      32'd0);
    chk("rst_done",    32'(done),      32'd0);
    chk("rst_timeout", 32'(timeout),   32'd0);
    chk("rst_trig",    32'(trigger_o), 32'd0);
    chk("rst_ena",     32'(core_ena),  32'd0);
    chk("rst_rdata",   host_rdata,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_banks("rst");

    // Random fill of every word of every bank, plus out-of-range and sel=3 writes.
    for (int b = 0; b < 3; b++)
      for (int i = 0; i < NW; i++)
        tbl.push_back('{sel: 2'(b), addr: 4'(i), data: $urandom});
    for (int i = NW; i < 16; i++)
      tbl.push_back('{sel: 2'($urandom_range(0, 2)), addr: 4'(i), data: $urandom});
    tbl.push_back('{sel: 2'd3, addr: 4'd0, data: 32'hFFFF0000});
    for (int i = 0; i < tbl.size(); i++) host_write(tbl[i].sel, tbl[i].addr, tbl[i].data);
    check_banks("rand");

    // P-256 base point with k = 1.
    tbl.delete();
    for (int i = 0; i < NW; i++) begin
      tbl.push_back('{sel: 2'd0, addr: 4'(i), data: (i == 0) ? 32'd1 : 32'd0});
      tbl.push_back('{sel: 2'd1, addr: 4'(i), data: (i < 8) ? p256_gx[i] : 32'd0});
      tbl.push_back('{sel: 2'd2, addr: 4'(i), data: (i < 8) ? p256_gy[i] : 32'd0});
    end
    for (int i = 0; i < tbl.size(); i++) host_write(tbl[i].sel, tbl[i].addr, tbl[i].data);
    check_banks("p256");

    do_run("run1", 1'b1, 1'b0, 32'd0);
    check_banks("run1");

    // Result write and host read of the same word in one cycle: old value first.
    core_rx_wren = 1'b1; core_rx_addr = 4'd3; core_rx_word = 32'h12345678;
    host_addr = 4'd3; host_rsel = 1'b0;
    tick();
    core_rx_wren = 1'b0;
    chk("rw_same_old", host_rdata, rx_m[3]);
    rx_m[3] = 32'h12345678;
    tick();
    chk("rw_same_new", host_rdata, rx_m[3]);

    do_run("run2", 1'b0, 1'b1, 32'hA5A50001);
    check_banks("run2");

    // Core never returns rdy: timeout after exactly TO RUN cycles.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    core_rdy = 1'b0;
    t0 = trig_cnt;
    chk("to_run_entry", 32'(trigger_o), 32'd1);
    chk("to_done_clr",  32'(done),      32'd0);
    n = 0;
    while (!timeout && n < 300) begin
      tick();
      n++;
    end
    chk("to_cycles",     32'(n),             32'(TO));
    chk("to_trig_width", 32'(trig_cnt - t0), 32'(TO));
    chk("to_trig_off",   32'(trigger_o),     32'd0);
`ifdef ECC_PMUL_KEY_WIPE_EN
    chk("to_done_wipe", 32'(done), 32'd0);
    repeat (NW) tick();
    for (int i = 0; i < 16; i++) k_m[i] = '0;
`endif
    chk("to_done", 32'(done), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    core_rdy = 1'b1;

    // Asynchronous reset in the middle of RUN.
    host_addr = 4'd3; host_rsel = 1'b0;
    core_k_addr = 4'd0; core_gx_addr = 4'd0; core_gy_addr = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    core_rdy = 1'b0;
    tick();
    chk("mid_trig_pre",  32'(trigger_o), 32'd1);
    chk("mid_rdata_pre", host_rdata,     rx_m[3]);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_busy",    32'(busy),      32'd0);
    chk("mid_done",    32'(done),      32'd0);
    chk("mid_timeout", 32'(timeout),   32'd0);
    chk("mid_trig",    32'(trigger_o), 32'd0);
    chk("mid_ena",     32'(core_ena),  32'd0);
    chk("mid_rdata",   host_rdata,     32'd0);
    chk("mid_gxword",  core_gx_word,   32'd0);
    core_rdy = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    tick();
    check_banks("post_rst");
    chk("post_rst_busy", 32'(busy), 32'd0);
    host_write(2'd0, 4'd5, 32'hCAFE0005);
    check_banks("post_rst_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
